// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared FSM state encoding and NOP constant for the IMEM loader arbiter.
package imem_ctrl_pkg;
  typedef enum logic [1:0] {RUN, LOAD, WRITE, DONE} state_e;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs accepted bytes little-endian into a 32-bit word buffer.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] buf_q, buf_d;
  always_comb begin
    byte_cnt_d = clr_i ? 2'd0 : en_i ? byte_cnt_q + 2'd1 : byte_cnt_q;
    buf_d = buf_q;
    if (en_i) buf_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      buf_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      buf_q <= buf_d;
    end
  end
  assign word_o = buf_q;
  assign word_full_o = en_i && byte_cnt_q == 2'd3;
endmodule

// File: rtl/imem_loader_arb.sv
// imem_loader_arb: shares IMEM between CPU fetch and a byte-serial loader.
// Define IMEM_LOADER_CHECKSUM_EN to accumulate a sum of written words on ld_csum.
module imem_loader_arb
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_done,
  output logic [31:0]   ld_csum,
  input  logic [31:0]   cpu_pc,
  output logic [31:0]   cpu_instr,
  output logic          cpu_stall,
  output logic          fetch_fault,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata
);
  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d, len_clamp;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]   word;
  logic          word_full, run, start;
  assign run = state_q == RUN;
  assign start = run && ld_start;
  assign len_clamp = ld_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : ld_len;
  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start || state_q == WRITE),
    .en_i        (ld_valid && ld_ready),
    .byte_i      (ld_byte),
    .word_o      (word),
    .word_full_o (word_full)
  );
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      RUN: if (ld_start) begin
        len_d = len_clamp;
        word_cnt_d = '0;
        state_d = len_clamp == '0 ? DONE : LOAD;
      end
      LOAD: state_d = word_full ? WRITE : LOAD;
      WRITE: begin
        word_cnt_d = word_cnt_q + AW'(1);
        state_d = {1'b0, word_cnt_q} == len_q - (AW+1)'(1) ? DONE : LOAD;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      len_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      word_cnt_q <= word_cnt_d;
    end
  end
  assign ld_ready = state_q == LOAD;
  assign ld_busy = !run;
  assign ld_done = state_q == DONE;
  assign cpu_stall = !run;
  assign mem_we = state_q == WRITE;
  assign mem_waddr = mem_we ? word_cnt_q : '0;
  assign mem_wdata = mem_we ? word : '0;
  // Fetch path is purely combinational so RUN-mode fetch has no added latency.
  assign fetch_fault = run && (cpu_pc[1:0] != 2'b00 || cpu_pc[31:AW+2] != '0);
  assign mem_raddr = run ? cpu_pc[AW+1:2] : '0;
  assign cpu_instr = run && !fetch_fault ? mem_rdata : NOP_INSTR;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk) begin
    if (rst || start) csum_q <= '0;
    else if (mem_we) csum_q <= csum_q + mem_wdata;
  end
  assign ld_csum = csum_q;
`else
  assign ld_csum = '0;
`endif
endmodule

// File: tb/tb_imem_loader_arb.sv
// tb_imem_loader_arb: directed checks of fetch, load sessions, reset abort and loader gaps.
module tb_imem_loader_arb;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic          clk = 0, rst = 1, ld_start = 0, ld_valid = 0;
  logic [AW:0]   ld_len = '0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready, ld_busy, ld_done, cpu_stall, fetch_fault, mem_we;
  logic [31:0]   ld_csum, cpu_pc = '0, cpu_instr, mem_rdata, mem_wdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [31:0]   mem [DEPTH];
  logic          pre_we = 0;
  logic [AW-1:0] pre_a = '0;
  logic [31:0]   pre_d = '0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  int            total = 0, bad = 0, acc_n = 0, base, cyc, wi, wr0;
  logic          gaps = 0, seen;
  logic [7:0]    q [$];
  logic [31:0]   exp_csum;
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_raddr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
      last_waddr <= mem_waddr;
    end else if (pre_we) mem[pre_a] <= pre_d;
  end
  imem_loader_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done),
    .ld_csum(ld_csum), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .fetch_fault(fetch_fault), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic acc;
    ld_valid = q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0);
    ld_byte = q.size() > 0 ? q[0] : 8'h00;
    #1;
    acc = ld_valid && ld_ready;
    @(posedge clk);
    #1;
    ld_start = 0;
    if (acc) begin
      void'(q.pop_front());
      acc_n++;
    end
  endtask
  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    pre_we = 1;
    pre_a = a;
    pre_d = d;
    @(posedge clk);
    #1;
    pre_we = 0;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) poke(AW'(i), 32'h0);
    poke(6'd2, 32'h0050_0093);
    tick();
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", ld_busy, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_csum", ld_csum, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst = 0;
    cpu_pc = 32'h8;
    #1;
    chk("fetch_instr", cpu_instr, 32'h0050_0093);
    chk("fetch_fault0", fetch_fault, 0);
    // Two-word load with ld_valid held high.
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    base = acc_n;
    wr0 = wr_cnt;
    ld_start = 1;
    ld_len = 7'd2;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("l2_we", mem_we, c == 5 || c == 10);
      chk("l2_done", ld_done, c == 11);
      chk("l2_stall", cpu_stall, c <= 11);
      if (c == 3) chk("l2_nop", cpu_instr, NOP);
      if (c == 5) begin
        chk("l2_waddr0", mem_waddr, 0);
        chk("l2_wdata0", mem_wdata, 32'h0000_0013);
      end
      if (c == 10) begin
        chk("l2_waddr1", mem_waddr, 1);
        chk("l2_wdata1", mem_wdata, 32'h0050_0093);
      end
    end
    chk("l2_bytes", acc_n - base, 8);
    chk("l2_wrs", wr_cnt - wr0, 2);
    chk("l2_mem0", mem[0], 32'h0000_0013);
    chk("l2_mem1", mem[1], 32'h0050_0093);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("l2_csum", ld_csum, 32'h0050_00A6);
`else
    chk("l2_csum", ld_csum, 32'h0);
`endif
    cpu_pc = 32'h6;
    #1;
    chk("mis_fault", fetch_fault, 1);
    chk("mis_instr", cpu_instr, NOP);
    cpu_pc = 32'h100;
    #1;
    chk("oor_fault", fetch_fault, 1);
    cpu_pc = 32'h4;
    #1;
    chk("pc4_instr", cpu_instr, 32'h0050_0093);
    // Zero-length session.
    wr0 = wr_cnt;
    ld_start = 1;
    ld_len = 7'd0;
    tick();
    chk("l0_done", ld_done, 1);
    chk("l0_busy", ld_busy, 1);
    chk("l0_we", mem_we, 0);
    tick();
    chk("l0_done2", ld_done, 0);
    chk("l0_busy2", ld_busy, 0);
    chk("l0_wrs", wr_cnt - wr0, 0);
    // Oversized length clamps to DEPTH.
    for (int k = 0; k < 4 * DEPTH; k++) q.push_back(8'(k));
    exp_csum = 0;
    for (int w = 0; w < DEPTH; w++) exp_csum += {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    wr0 = wr_cnt;
    ld_start = 1;
    ld_len = 7'd100;
    cyc = 0;
    seen = 0;
    while (cyc < 400 && !seen) begin
      tick();
      cyc++;
      seen = ld_done;
    end
    chk("big_done_cyc", cyc, 5 * DEPTH + 1);
    chk("big_wrs", wr_cnt - wr0, DEPTH);
    chk("big_last", last_waddr, DEPTH - 1);
    chk("big_mem63", mem[63], 32'hFFFE_FDFC);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("big_csum", ld_csum, exp_csum);
`else
    chk("big_csum", ld_csum, 32'h0);
`endif
    tick();
    chk("big_run", cpu_stall, 0);
    // Reset after six bytes of a two-word load; mid-session ld_start ignored.
    poke(6'd0, 32'hDEAD_BEEF);
    poke(6'd1, 32'hDEAD_BEEF);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    base = acc_n;
    wr0 = wr_cnt;
    ld_start = 1;
    ld_len = 7'd2;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) begin
        ld_start = 1;
        ld_len = 7'd0;
      end
      if (c == 4) begin
        chk("mid_busy", ld_busy, 1);
        chk("mid_done", ld_done, 0);
        chk("mid_ready", ld_ready, 1);
      end
    end
    chk("ra_bytes", acc_n - base, 6);
    rst = 1;
    tick();
    rst = 0;
    q.delete();
    chk("ra_stall", cpu_stall, 0);
    chk("ra_ready", ld_ready, 0);
    chk("ra_busy", ld_busy, 0);
    chk("ra_csum", ld_csum, 0);
    chk("ra_wrs", wr_cnt - wr0, 1);
    chk("ra_mem0", mem[0], 32'h4433_2211);
    chk("ra_mem1", mem[1], 32'hDEAD_BEEF);
    // Random ld_valid gaps.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    gaps = 1;
    base = acc_n;
    wi = 0;
    seen = 0;
    ld_start = 1;
    ld_len = 7'd2;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      seen = ld_done;
      if (!seen) chk("gap_stall", cpu_stall, 1);
      if (mem_we) begin
        chk("gap_addr", mem_waddr, wi);
        chk("gap_early", acc_n - base, 4 * (wi + 1));
        wi++;
      end
    end
    gaps = 0;
    chk("gap_timeout", seen, 1);
    chk("gap_words", wi, 2);
    tick();
    chk("gap_mem0", mem[0], 32'h0403_0201);
    chk("gap_mem1", mem[1], 32'h0807_0605);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
